// File: rtl/header_extraction_pkg.sv
// rtl/header_extraction_pkg.sv - shared state encodings and byte-count helpers for header insert/extract
package header_extraction_pkg;

  typedef enum logic [7:0] {
    CAPTURE_HEADER = 8'h01,
    STREAM         = 8'h02,
    FLUSH          = 8'h04
  } state_e;

  function automatic int bytes_per_beat(input int bits_per_beat);
    return bits_per_beat / 8;
  endfunction

  function automatic int bytes_per_header(input int header_size);
    return header_size / 8;
  endfunction

endpackage

// File: rtl/header_extraction_if.sv
// rtl/header_extraction_if.sv - stream in/out plus header side port bundle
interface header_extraction_if
  import header_extraction_pkg::*;
#(
  parameter int BITS_PER_BEAT = 512,
  parameter int HEADER_SIZE   = 112
);
  localparam int BB = bytes_per_beat(BITS_PER_BEAT);

  logic                     tvalid_in;
  logic [BITS_PER_BEAT-1:0] tdata_in;
  logic                     tlast_in;
  logic [BB-1:0]            tkeep_in;
  logic                     tready_out;
  logic                     tvalid_out;
  logic [BITS_PER_BEAT-1:0] tdata_out;
  logic                     tlast_out;
  logic [BB-1:0]            tkeep_out;
  logic                     tready_in;
  logic [HEADER_SIZE-1:0]   header_data;
  logic                     header_valid;
  logic                     runt_error;

  modport slave (
    input  tvalid_in, tdata_in, tlast_in, tkeep_in, tready_in,
    output tready_out, tvalid_out, tdata_out, tlast_out, tkeep_out,
    output header_data, header_valid, runt_error
  );

  modport master (
    output tvalid_in, tdata_in, tlast_in, tkeep_in, tready_in,
    input  tready_out, tvalid_out, tdata_out, tlast_out, tkeep_out,
    input  header_data, header_valid, runt_error
  );

endinterface

// File: rtl/header_extraction_axis_output_register.sv
// rtl/header_extraction_axis_output_register.sv - one-deep stream holding register
module axis_output_register #(
  parameter int DATA_W = 512,
  parameter int KEEP_W = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [KEEP_W-1:0] keep_i,
  input  logic              last_i,
  input  logic              ready_i,
  output logic              free_o,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [KEEP_W-1:0] keep_o,
  output logic              last_o
);
  logic              valid_q;
  logic [DATA_W-1:0] data_q;
  logic [KEEP_W-1:0] keep_q;
  logic              last_q;

  // Free when empty or when the held beat is consumed this cycle.
  assign free_o = !valid_q || ready_i;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
    end else if (free_o) begin
      valid_q <= load_i;
      if (load_i) begin
        data_q <= data_i;
        keep_q <= keep_i;
        last_q <= last_i;
      end
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign keep_o  = keep_q;
  assign last_o  = last_q;

endmodule

// File: rtl/header_extraction.sv
// rtl/header_extraction.sv - strips the leading header from each packet and re-aligns the payload to lane 0
module header_extraction
  import header_extraction_pkg::*;
#(
  parameter int BITS_PER_BEAT = 512,
  parameter int HEADER_SIZE   = 112
) (
  input logic                clock,
  input logic                reset,
  header_extraction_if.slave bus
);
  localparam int B  = BITS_PER_BEAT;
  localparam int H  = HEADER_SIZE;
  localparam int BB = bytes_per_beat(B);
  localparam int HB = bytes_per_header(H);
  localparam int LB = B - H;
  localparam int LK = BB - HB;

  state_e          state_q, state_d;
  logic [LB-1:0]   leftover_q, leftover_d;
  logic [LK-1:0]   keep_left_q, keep_left_d;
  logic [H-1:0]    header_q, header_d;
  logic            header_valid_q, header_valid_d;
  logic            runt_q, runt_d;
  logic            out_load, out_last, out_free;
  logic [B-1:0]    out_data;
  logic [BB-1:0]   out_keep;
  logic            accept, upper_keep_any;

  assign bus.tready_out = (state_q != FLUSH) && out_free;
  assign accept         = bus.tvalid_in && bus.tready_out;
  assign upper_keep_any = |bus.tkeep_in[BB-1:HB];

  always_comb begin
    state_d        = state_q;
    leftover_d     = leftover_q;
    keep_left_d    = keep_left_q;
    header_d       = header_q;
    header_valid_d = 1'b0;
    runt_d         = 1'b0;
    out_load       = 1'b0;
    out_data       = {{H{1'b0}}, leftover_q};
    out_keep       = {{HB{1'b0}}, keep_left_q};
    out_last       = 1'b1;
    case (state_q)
      CAPTURE_HEADER: begin
        if (accept) begin
          if (bus.tlast_in && !(&bus.tkeep_in[HB-1:0])) begin
            runt_d = 1'b1;
          end else begin
            header_d       = bus.tdata_in[H-1:0];
            header_valid_d = 1'b1;
            leftover_d     = bus.tdata_in[B-1:H];
            keep_left_d    = bus.tkeep_in[BB-1:HB];
            out_data       = {{H{1'b0}}, bus.tdata_in[B-1:H]};
            out_keep       = {{HB{1'b0}}, bus.tkeep_in[BB-1:HB]};
            if (bus.tlast_in) out_load = upper_keep_any;
            else              state_d  = STREAM;
          end
        end
      end
      STREAM: begin
        if (accept) begin
          out_load    = 1'b1;
          out_data    = {bus.tdata_in[H-1:0], leftover_q};
          out_keep    = {bus.tkeep_in[HB-1:0], keep_left_q};
          out_last    = bus.tlast_in && !upper_keep_any;
          leftover_d  = bus.tdata_in[B-1:H];
          keep_left_d = bus.tkeep_in[BB-1:HB];
          // Bytes left over past the last beat need one extra output beat.
          if (bus.tlast_in) state_d = upper_keep_any ? FLUSH : CAPTURE_HEADER;
        end
      end
      FLUSH: begin
        if (out_free) begin
          out_load = 1'b1;
          state_d  = CAPTURE_HEADER;
        end
      end
      default: state_d = CAPTURE_HEADER;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= CAPTURE_HEADER;
      leftover_q     <= '0;
      keep_left_q    <= '0;
      header_q       <= '0;
      header_valid_q <= 1'b0;
      runt_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      leftover_q     <= leftover_d;
      keep_left_q    <= keep_left_d;
      header_q       <= header_d;
      header_valid_q <= header_valid_d;
      runt_q         <= runt_d;
    end
  end

  assign bus.header_data  = header_q;
  assign bus.header_valid = header_valid_q;
  assign bus.runt_error   = runt_q;

  axis_output_register #(
    .DATA_W(B),
    .KEEP_W(BB)
  ) u_out_reg (
    .clock  (clock),
    .reset  (reset),
    .load_i (out_load),
    .data_i (out_data),
    .keep_i (out_keep),
    .last_i (out_last),
    .ready_i(bus.tready_in),
    .free_o (out_free),
    .valid_o(bus.tvalid_out),
    .data_o (bus.tdata_out),
    .keep_o (bus.tkeep_out),
    .last_o (bus.tlast_out)
  );

endmodule
